// File: rtl/fifo_ptr_pkg.sv
// ============================================================================
// fifo_ptr_pkg : Gray/binary pointer helpers shared by the FIFO pointer blocks
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package fifo_ptr_pkg;

  // Widest pointer supported (ADDRSIZE up to 16, plus the wrap bit).
  localparam int unsigned PTR_MAXW = 17;

  typedef logic [PTR_MAXW-1:0] ptr_word_t;

  function automatic ptr_word_t bin2gray(input ptr_word_t bin);
    return (bin >> 1) ^ bin;
  endfunction

  function automatic ptr_word_t gray2bin(input ptr_word_t gray);
    ptr_word_t bin;
    bin[PTR_MAXW-1] = gray[PTR_MAXW-1];
    for (int i = PTR_MAXW - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  // Gray value the write pointer holds when it is exactly one lap ahead of
  // the given read pointer: top two bits inverted, the rest unchanged.
  function automatic ptr_word_t full_match(input ptr_word_t rd_gray, input int unsigned aw);
    return rd_gray ^ (ptr_word_t'(3) << (aw - 1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/gray_to_bin.sv
// ============================================================================
// gray_to_bin : combinational Gray-to-binary converter, WIDTH bits (max 17)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module gray_to_bin
  import fifo_ptr_pkg::*;
#(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  assign bin = WIDTH'(gray2bin(ptr_word_t'(gray)));

endmodule

`default_nettype wire

// File: rtl/wr_ptr_full_level.sv
// ============================================================================
// wr_ptr_full_level : FIFO write pointer, full flag, fill level, almost-full
//                     and sticky overflow, all in the write clock domain.
//                     Almost-full logic is built only with WPTR_AFULL_EN.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module wr_ptr_full_level
  import fifo_ptr_pkg::*;
#(
  parameter int unsigned ADDRSIZE = 4
) (
  input  logic                wr_clk,
  input  logic                wr_rst,
  input  logic                wr_en,
  input  logic [ADDRSIZE:0]   wq2_rd_ptr,
  input  logic [ADDRSIZE:0]   wr_af_thresh,
  input  logic                wr_ovf_clr,
  output logic                wr_accept,
  output logic [ADDRSIZE-1:0] wr_addr,
  output logic [ADDRSIZE:0]   wr_grayptr,
  output logic                wr_full,
  output logic [ADDRSIZE:0]   wr_level,
  output logic                wr_almost_full,
  output logic                wr_overflow
);

  localparam int unsigned PW = ADDRSIZE + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] ptr_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] full_pattern;
  logic [PW-1:0] rd_bin;
  logic [PW-1:0] level_next;
  logic          full_next;
  logic          afull_next;

  assign wr_accept = wr_en & ~wr_full;
  assign wr_addr   = wr_ptr[ADDRSIZE-1:0];

  assign ptr_next     = wr_ptr + PW'(wr_accept);
  assign gray_next    = PW'(bin2gray(ptr_word_t'(ptr_next)));
  assign full_pattern = PW'(full_match(ptr_word_t'(wq2_rd_ptr), ADDRSIZE));
  assign full_next    = (gray_next == full_pattern);

  gray_to_bin #(
    .WIDTH (PW)
  ) u_rd_gray_to_bin (
    .gray (wq2_rd_ptr),
    .bin  (rd_bin)
  );

  // Read pointer lags the real reader, so this level can only over-report.
  assign level_next = ptr_next - rd_bin;

`ifdef WPTR_AFULL_EN
  assign afull_next = (level_next >= wr_af_thresh);
`else
  logic unused_af_thresh;
  assign unused_af_thresh = ^wr_af_thresh;
  assign afull_next       = 1'b0;
`endif

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      wr_ptr         <= '0;
      wr_grayptr     <= '0;
      wr_full        <= 1'b0;
      wr_level       <= '0;
      wr_almost_full <= 1'b0;
      wr_overflow    <= 1'b0;
    end else begin
      wr_ptr         <= ptr_next;
      wr_grayptr     <= gray_next;
      wr_full        <= full_next;
      wr_level       <= level_next;
      wr_almost_full <= afull_next;
      wr_overflow    <= (wr_overflow & ~wr_ovf_clr) | (wr_en & wr_full);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wr_ptr_full_level.sv
// ============================================================================
// tb_wr_ptr_full_level : scoreboard bench for wr_ptr_full_level (ADDRSIZE=4)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_wr_ptr_full_level;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int PMOD  = 2 * DEPTH;

  logic          wr_clk = 1'b0;
  logic          wr_rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW:0]   wq2_rd_ptr = '0;
  logic [AW:0]   wr_af_thresh = '0;
  logic          wr_ovf_clr = 1'b0;
  logic          wr_accept;
  logic [AW-1:0] wr_addr;
  logic [AW:0]   wr_grayptr;
  logic          wr_full;
  logic [AW:0]   wr_level;
  logic          wr_almost_full;
  logic          wr_overflow;

  wr_ptr_full_level #(.ADDRSIZE(AW)) dut (
    .wr_clk         (wr_clk),
    .wr_rst         (wr_rst),
    .wr_en          (wr_en),
    .wq2_rd_ptr     (wq2_rd_ptr),
    .wr_af_thresh   (wr_af_thresh),
    .wr_ovf_clr     (wr_ovf_clr),
    .wr_accept      (wr_accept),
    .wr_addr        (wr_addr),
    .wr_grayptr     (wr_grayptr),
    .wr_full        (wr_full),
    .wr_level       (wr_level),
    .wr_almost_full (wr_almost_full),
    .wr_overflow    (wr_overflow)
  );

  always #5 wr_clk = ~wr_clk;

  typedef struct {
    bit comb;
    int acc;
    int addr;
    int gray;
    int full;
    int level;
    int af;
    int ovf;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_errors = 0;

  // Reference state: unbounded word counts for writer and (synchronised) reader.
  int  wr_cnt = 0;
  int  rd_cnt = 0;
  bit  m_full = 1'b0;
  bit  m_ovf  = 1'b0;
  bit  first  = 1'b1;

  function automatic int gray(input int v);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit en, input int adv, input int thr, input bit clr, input bit rst);
    exp_t e;
    int lvl;
    @(posedge wr_clk);
    #1;
    if (rst) rd_cnt = 0;
    else if (rd_cnt + adv <= wr_cnt) rd_cnt = rd_cnt + adv;
    else rd_cnt = wr_cnt;
    wr_en        = en;
    wr_rst       = rst;
    wr_ovf_clr   = clr;
    wr_af_thresh = (AW+1)'(thr);
    wq2_rd_ptr   = (AW+1)'(gray(rd_cnt % PMOD));
    e.comb = !first;
    first  = 1'b0;
    e.acc  = (en && !m_full) ? 1 : 0;
    e.addr = wr_cnt % DEPTH;
    if (rst) begin
      wr_cnt = 0;
      m_full = 1'b0;
      m_ovf  = 1'b0;
      e.af   = 0;
    end else begin
      m_ovf = (m_ovf && !clr) || (en && m_full);
      if (e.acc == 1) wr_cnt++;
      lvl    = wr_cnt - rd_cnt;
      m_full = (lvl == DEPTH);
`ifdef WPTR_AFULL_EN
      e.af = (lvl >= thr) ? 1 : 0;
`else
      e.af = 0;
`endif
    end
    e.gray  = gray(wr_cnt % PMOD);
    e.full  = m_full ? 1 : 0;
    e.level = wr_cnt - rd_cnt;
    e.ovf   = m_ovf ? 1 : 0;
    q.push_back(e);
  endtask

  // Monitor: combinational outputs mid-cycle, registered outputs after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge wr_clk);
      if (q.size() > 0) begin
        e = q[0];
        if (e.comb) begin
          chk("wr_accept", 32'(wr_accept), e.acc);
          chk("wr_addr", 32'(wr_addr), e.addr);
        end
        @(posedge wr_clk);
        #2;
        chk("wr_grayptr", 32'(wr_grayptr), e.gray);
        chk("wr_full", 32'(wr_full), e.full);
        chk("wr_level", 32'(wr_level), e.level);
        chk("wr_almost_full", 32'(wr_almost_full), e.af);
        chk("wr_overflow", 32'(wr_overflow), e.ovf);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    int adv;
    int waited;
    step(0, 0, 20, 0, 1);
    // Fill to full with the reader parked, then one write too many.
    for (int i = 0; i < 16; i++) step(1, 0, 20, 0, 0);
    step(1, 0, 20, 0, 0);
    // Overflow set/clear race, then plain clear.
    step(1, 0, 20, 1, 0);
    step(0, 0, 20, 1, 0);
    step(0, 0, 20, 0, 0);
    // Almost-full at threshold 12, then the reader advances by 4.
    step(0, 0, 12, 0, 1);
    for (int i = 0; i < 12; i++) step(1, 0, 12, 0, 0);
    step(0, 4, 12, 0, 0);
    step(0, 0, 12, 0, 0);
    // Mid-stream reset with a write pending.
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    // Wrap-around with the reader tracking the writer.
    step(0, 0, 3, 0, 1);
    for (int i = 0; i < 33; i++) step(1, wr_cnt - rd_cnt, 3, 0, 0);
    // Randomised traffic.
    for (int i = 0; i < 500; i++) begin
      adv = ($urandom % 3 == 0) ? int'($urandom_range(0, 16)) : 0;
      step(($urandom % 4) != 0, adv, int'($urandom_range(0, 20)),
           ($urandom % 8) == 0, ($urandom % 100) == 0);
    end
    step(0, 0, 0, 0, 0);
    waited = 0;
    while (q.size() > 0 && waited < 10) begin
      @(posedge wr_clk);
      waited++;
    end
    #3;
    if (q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
